// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one combinational adder between N_REQ requesters.
// Grant in IDLE -> operands on adder in EXEC -> registered result in RESP, held until res_ready.
module add_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 10,
  parameter int RES_WIDTH = 12,
  parameter int ID_W      = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]       add_a,
  output logic [WIDTH-1:0]       add_b,
  input  logic [RES_WIDTH-1:0]   add_sum,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [RES_WIDTH-1:0]   res_sum,
  output logic [ID_W-1:0]        res_id,
  output logic                   busy,
  output logic [15:0]            ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                 state_q;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]        id_q;
  logic [WIDTH-1:0]       op_a_q, op_b_q;
  logic [RES_WIDTH-1:0]   sum_q;
  logic [15:0]            ops_q;

  logic                   hi_found, lo_found;
  logic [ID_W-1:0]        hi_idx, lo_idx, gnt_idx;
  logic [WIDTH-1:0]       sel_a, sel_b;

  // Lowest valid index at or above the pointer wins; otherwise wrap to the lowest valid index.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        if (k >= int'(rr_ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = ID_W'(k);
        end
        lo_found = 1'b1;
        lo_idx   = ID_W'(k);
      end
    end
    gnt_idx  = hi_found ? hi_idx : lo_idx;
    rr_ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_idx == ID_W'(k)) begin
        sel_a = req_a[k*WIDTH +: WIDTH];
        sel_b = req_b[k*WIDTH +: WIDTH];
      end
    end
  end

  assign req_ready = (state_q == IDLE && lo_found) ? (N_REQ'(1) << gnt_idx) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      sum_q    <= '0;
      ops_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (lo_found) begin
            op_a_q   <= sel_a;
            op_b_q   <= sel_b;
            id_q     <= gnt_idx;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          sum_q   <= add_sum;
          state_q <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            ops_q   <= ops_q + 16'd1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign add_a     = op_a_q;
  assign add_b     = op_b_q;
  assign res_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign res_sum   = sum_q;
  assign res_id    = id_q;
  assign ops_done  = ops_q;

endmodule

// File: tb/tb_add_arbiter.sv
// Bench for add_arbiter: transaction-level model compared every cycle, plus directed literal checks.
module tb_add_arbiter;
  localparam int N  = 4;
  localparam int W  = 10;
  localparam int R  = 12;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   add_a, add_b;
  logic [R-1:0]   add_sum;
  logic           res_valid;
  logic           res_ready = 1'b1;
  logic [R-1:0]   res_sum;
  logic [IW-1:0]  res_id;
  logic           busy;
  logic [15:0]    ops_done;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // The shared adder lives outside the arbiter.
  assign add_sum = R'(add_a) + R'(add_b);

  add_arbiter #(.N_REQ(N), .WIDTH(W), .RES_WIDTH(R), .ID_W(IW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_id(res_id),
    .busy(busy), .ops_done(ops_done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Transaction model: phase 0 waiting for grant, 1 adding, 2 holding the result.
  int          m_phase = 0;
  int          m_ptr   = 0;
  int          m_id    = 0;
  logic [W-1:0] m_a = '0, m_b = '0;
  logic [R-1:0] m_sum = '0;
  logic [15:0]  m_cnt = '0;
  logic         cnt_load = 1'b0;

  always @(posedge clk or posedge rst or posedge cnt_load) begin
    int g;
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_id = 0; m_a = '0; m_b = '0; m_sum = '0; m_cnt = '0;
    end else if (cnt_load) begin
      m_cnt = 16'hFFFF;
    end else begin
      case (m_phase)
        0: begin
          g = rr_pick(req_valid, m_ptr);
          if (g >= 0) begin
            m_a = req_a[g*W +: W];
            m_b = req_b[g*W +: W];
            m_id = g;
            m_ptr = (g + 1) % N;
            m_phase = 1;
          end
        end
        1: begin
          m_sum = R'(m_a) + R'(m_b);
          m_phase = 2;
        end
        default: begin
          if (res_ready) begin
            m_cnt = m_cnt + 16'd1;
            m_phase = 0;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    int g;
    logic [N-1:0] exp_rdy;
    g = rr_pick(req_valid, m_ptr);
    exp_rdy = '0;
    if (m_phase == 0 && g >= 0) exp_rdy[g] = 1'b1;
    chk("cmp_req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("cmp_res_valid", 32'(res_valid), 32'(m_phase == 2));
    chk("cmp_busy", 32'(busy), 32'(m_phase != 0));
    chk("cmp_add_a", 32'(add_a), 32'(m_a));
    chk("cmp_add_b", 32'(add_b), 32'(m_b));
    chk("cmp_ops_done", 32'(ops_done), 32'(m_cnt));
    if (m_phase == 2) begin
      chk("cmp_res_sum", 32'(res_sum), 32'(m_sum));
      chk("cmp_res_id", 32'(res_id), 32'(m_id));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  // Entered just after a rising edge with the DUT idle and res_ready high.
  task automatic run_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [R-1:0] exp_sum, input logic [15:0] exp_cnt, input string nm);
    logic [N-1:0] oh;
    oh = '0;
    oh[i] = 1'b1;
    set_op(i, a, b);
    req_valid = oh;
    neg(); chk({nm, "_ready"}, 32'(req_ready), 32'(oh));
    tick(); req_valid = '0;
    neg(); chk({nm, "_exec_valid"}, 32'(res_valid), 32'd0);
    chk({nm, "_exec_busy"}, 32'(busy), 32'd1);
    tick();
    neg(); chk({nm, "_valid"}, 32'(res_valid), 32'd1);
    chk({nm, "_sum"}, 32'(res_sum), 32'(exp_sum));
    chk({nm, "_id"}, 32'(res_id), 32'(i));
    tick();
    neg(); chk({nm, "_ops"}, 32'(ops_done), 32'(exp_cnt));
    chk({nm, "_idle"}, 32'(busy), 32'd0);
  endtask

  int gq[5];
  int sq[5];
  int iq[5];
  int gi, ri;
  int exp_g[5] = '{0, 1, 2, 3, 0};
  int exp_s[5] = '{11, 202, 303, 404, 11};

  initial begin
    repeat (2) tick();
    neg();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_add_a", 32'(add_a), 32'd0);
    chk("rst_res_sum", 32'(res_sum), 32'd0);
    chk("rst_ops", 32'(ops_done), 32'd0);
    tick(); rst = 1'b0;

    run_op(0, 10'd25, 10'd17, 12'd42, 16'd1, "single");
    tick();
    run_op(3, 10'd1023, 10'd1023, 12'd2046, 16'd2, "maxop");

    // Fairness: all four requesters held valid.
    tick();
    set_op(0, 10'd10, 10'd1); set_op(1, 10'd200, 10'd2);
    set_op(2, 10'd300, 10'd3); set_op(3, 10'd400, 10'd4);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin gq[k] = -1; sq[k] = -1; iq[k] = -1; end
    gi = 0; ri = 0;
    for (int c = 0; c < 40 && ri < 5; c++) begin
      neg();
      if (req_ready != '0 && gi < 5) begin
        for (int k = 0; k < N; k++) if (req_ready[k]) gq[gi] = k;
        gi++;
      end
      if (res_valid) begin sq[ri] = int'(res_sum); iq[ri] = int'(res_id); ri++; end
      tick();
    end
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      chk("fair_grant", 32'(gq[k]), 32'(exp_g[k]));
      chk("fair_sum", 32'(sq[k]), 32'(exp_s[k]));
      chk("fair_id", 32'(iq[k]), 32'(exp_g[k]));
    end

    // Backpressure: result held for 5 cycles while requester 0 waits.
    set_op(2, 10'd500, 10'd6); set_op(0, 10'd7, 10'd8);
    req_valid = 4'b0101; res_ready = 1'b0;
    neg(); chk("bp_first_grant", 32'(req_ready), 32'b0100);
    tick(); req_valid = 4'b0001;
    tick();
    for (int c = 0; c < 5; c++) begin
      neg();
      chk("bp_hold_valid", 32'(res_valid), 32'd1);
      chk("bp_hold_sum", 32'(res_sum), 32'd506);
      chk("bp_hold_id", 32'(res_id), 32'd2);
      chk("bp_no_grant", 32'(req_ready), 32'd0);
      tick();
    end
    res_ready = 1'b1;
    neg(); chk("bp_ready_cycle", 32'(req_ready), 32'd0);
    tick();
    neg(); chk("bp_next_grant", 32'(req_ready), 32'b0001);
    tick(); req_valid = '0;
    tick();
    neg(); chk("bp_second_sum", 32'(res_sum), 32'd15);
    chk("bp_second_id", 32'(res_id), 32'd0);
    tick();
    neg(); chk("bp_ops", 32'(ops_done), 32'd9);

    // Reset while in EXEC.
    tick();
    set_op(1, 10'd1, 10'd2); req_valid = 4'b0010;
    neg(); chk("mid_grant", 32'(req_ready), 32'b0010);
    tick(); req_valid = '0;
    neg(); chk("mid_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_add_a", 32'(add_a), 32'd0);
    chk("mid_rst_add_b", 32'(add_b), 32'd0);
    chk("mid_rst_ops", 32'(ops_done), 32'd0);
    chk("mid_rst_id", 32'(res_id), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    set_op(2, 10'd3, 10'd4); set_op(3, 10'd9, 10'd9);
    req_valid = 4'b1100;
    neg(); chk("post_rst_grant", 32'(req_ready), 32'b0100);
    tick(); req_valid = '0;
    tick();
    neg(); chk("post_rst_sum", 32'(res_sum), 32'd7);
    chk("post_rst_id", 32'(res_id), 32'd2);
    tick();
    neg(); chk("post_rst_ops", 32'(ops_done), 32'd1);

    // Counter wrap: preload the count to 0xFFFF, then one handshake.
    tick();
    force dut.ops_q = 16'hFFFF;
    cnt_load = 1'b1;
    #1;
    release dut.ops_q;
    cnt_load = 1'b0;
    neg(); chk("wrap_preload", 32'(ops_done), 32'hFFFF);
    tick();
    run_op(1, 10'd2, 10'd3, 12'd5, 16'h0000, "wrap");
    tick();
    run_op(2, 10'd1000, 10'd24, 12'd1024, 16'h0001, "after_wrap");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
